// File: rtl/imem_responder.sv
// imem_responder: direct-mapped instruction cache front end. Hits answer one
// cycle after acceptance; misses fetch a 32-byte line as a four-beat 64-bit
// burst from backing memory, install it and answer from the fill data.
//
// Handshakes: a fetch is taken in a cycle where input_valid && imem_read &&
// !imem_stall && !flush; imem_resp is a one-cycle pulse, with imem_rdata and
// imem_raddr holding their values while it is low. On the memory side
// bmem_read stays high (with a stable bmem_addr) until bmem_ready is seen
// high on a rising edge; afterwards every cycle with bmem_rvalid high carries
// one beat, beat k filling line bits [64k+63:64k].
module imem_responder #(
  parameter int LINES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        input_valid,
  input  logic        imem_read,
  input  logic [31:0] imem_addr,
  input  logic        flush,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  output logic [31:0] imem_raddr,
  output logic        imem_stall,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  input  logic        bmem_ready,
  input  logic        bmem_rvalid,
  input  logic [63:0] bmem_rdata,
  output logic [1:0]  dbg_state
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 27 - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_FILL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [255:0]       data_q [LINES];
  logic [31:0]        miss_addr_q, miss_addr_d;
  logic [1:0]         beat_q, beat_d;
  logic [191:0]       fill_q, fill_d;
  logic               kill_q, kill_d;
  logic               resp_q, resp_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        raddr_q, raddr_d;
  logic               bread_q, bread_d;
  logic [31:0]        baddr_q, baddr_d;

  logic [IDX_W-1:0]   req_idx, miss_idx;
  logic [TAG_W-1:0]   req_tag, miss_tag;
  logic [2:0]         req_off, miss_off;
  logic [255:0]       hit_line, fill_line;
  logic [31:0]        hit_word, fill_word;
  logic               accept, req_hit, install;

  assign imem_stall = (state_q != IDLE);
  assign accept     = input_valid && imem_read && !imem_stall && !flush;

  assign req_idx    = imem_addr[5 +: IDX_W];
  assign req_tag    = imem_addr[31 -: TAG_W];
  assign req_off    = imem_addr[4:2];
  assign miss_idx   = miss_addr_q[5 +: IDX_W];
  assign miss_tag   = miss_addr_q[31 -: TAG_W];
  assign miss_off   = miss_addr_q[4:2];

  assign hit_line   = data_q[req_idx];
  assign hit_word   = hit_line[{req_off, 5'b00000} +: 32];
  assign req_hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // The last beat arrives straight from the bus; earlier beats sit in fill_q.
  assign fill_line  = {bmem_rdata, fill_q};
  assign fill_word  = fill_line[{miss_off, 5'b00000} +: 32];
  assign install    = (state_q == MISS_FILL) && bmem_rvalid && (beat_q == 2'd3);

  // Next-state and registered-output logic for the hit/miss/fill sequence.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    miss_addr_d = miss_addr_q;
    beat_d      = beat_q;
    fill_d      = fill_q;
    kill_d      = kill_q;
    resp_d      = 1'b0;
    rdata_d     = rdata_q;
    raddr_d     = raddr_q;
    bread_d     = bread_q;
    baddr_d     = baddr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_hit) begin
            resp_d  = 1'b1;
            rdata_d = hit_word;
            raddr_d = imem_addr;
          end else begin
            miss_addr_d = imem_addr;
            kill_d      = 1'b0;
            bread_d     = 1'b1;
            baddr_d     = {imem_addr[31:5], 5'b00000};
            state_d     = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        // A flush only cancels the answer; the line is still fetched.
        if (flush) kill_d = 1'b1;
        if (bmem_ready) begin
          bread_d = 1'b0;
          beat_d  = 2'd0;
          state_d = MISS_FILL;
        end
      end
      MISS_FILL: begin
        if (flush) kill_d = 1'b1;
        if (bmem_rvalid) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            valid_d[miss_idx] = 1'b1;
            state_d           = IDLE;
            kill_d            = 1'b0;
            if (!(kill_q || flush)) begin
              resp_d  = 1'b1;
              rdata_d = fill_word;
              raddr_d = miss_addr_q;
            end
          end else begin
            case (beat_q)
              2'd0:    fill_d[63:0]    = bmem_rdata;
              2'd1:    fill_d[127:64]  = bmem_rdata;
              default: fill_d[191:128] = bmem_rdata;
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, valid bits and outputs; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      beat_q      <= 2'd0;
      fill_q      <= '0;
      kill_q      <= 1'b0;
      resp_q      <= 1'b0;
      rdata_q     <= '0;
      raddr_q     <= '0;
      bread_q     <= 1'b0;
      baddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
      beat_q      <= beat_d;
      fill_q      <= fill_d;
      kill_q      <= kill_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata_d;
      raddr_q     <= raddr_d;
      bread_q     <= bread_d;
      baddr_q     <= baddr_d;
    end
  end

  // Tag and data arrays need no reset: valid_q guards every lookup.
  always_ff @(posedge clk) begin
    if (install) begin
      data_q[miss_idx] <= fill_line;
      tag_q[miss_idx]  <= miss_tag;
    end
  end

  assign imem_resp  = resp_q;
  assign imem_rdata = rdata_q;
  assign imem_raddr = raddr_q;
  assign bmem_read  = bread_q;
  assign bmem_addr  = baddr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed and randomized fetches against a cache model
// that tracks which line address each index holds, plus a backing memory
// whose contents are a fixed function of the word address.
module tb_imem_responder;

  localparam int LINES = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        input_valid;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic        flush;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] imem_raddr;
  logic        imem_stall;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready;
  logic        bmem_rvalid;
  logic [63:0] bmem_rdata;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int bursts = 0;
  logic [31:0] last_raddr;
  logic [31:0] last_rdata;

  // Reference cache: per index, whether it holds a line and which one.
  logic        ref_valid [LINES];
  logic [26:0] ref_line  [LINES];

  // Clock generation.
  always #5 clk = ~clk;

  imem_responder #(.LINES(LINES)) dut (
    .clk(clk), .rst(rst), .input_valid(input_valid), .imem_read(imem_read),
    .imem_addr(imem_addr), .flush(flush), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .imem_raddr(imem_raddr), .imem_stall(imem_stall),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_ready(bmem_ready),
    .bmem_rvalid(bmem_rvalid), .bmem_rdata(bmem_rdata), .dbg_state(dbg_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [63:0] beat_data(input logic [31:0] a, input int k);
    logic [31:0] base;
    base = {a[31:5], 5'b00000} + 32'(8 * k);
    return {mem_word(base + 32'd4), mem_word(base)};
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[31:5] % 27'(LINES));
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    return ref_valid[idx_of(a)] && (ref_line[idx_of(a)] == a[31:5]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) begin
      ref_valid[i] = 1'b0;
      ref_line[i]  = '0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_resp"},  32'(imem_resp),  0);
    check({tag, "_stall"}, 32'(imem_stall), 0);
    check({tag, "_rdata"}, imem_rdata,      0);
    check({tag, "_raddr"}, imem_raddr,      0);
    check({tag, "_bread"}, 32'(bmem_read),  0);
    check({tag, "_baddr"}, bmem_addr,       0);
  endtask

  // One fetch, serving the burst if it misses. flush_beat / rst_beat pick the
  // beat at which a flush pulse is applied or after which reset is asserted.
  task automatic fetch(input logic [31:0] a, input int flush_beat, input int rst_beat);
    logic hit;
    logic killed;
    int   n;
    @(negedge clk);
    check("idle_stall", 32'(imem_stall), 0);
    input_valid = 1'b1;
    imem_read   = 1'b1;
    imem_addr   = a;
    hit         = model_hit(a);
    @(negedge clk);
    if (hit) begin
      input_valid = 1'b0;
      imem_read   = 1'b0;
      check("hit_resp",  32'(imem_resp),  1);
      check("hit_rdata", imem_rdata,      mem_word(a));
      check("hit_raddr", imem_raddr,      a);
      check("hit_stall", 32'(imem_stall), 0);
      last_raddr = a;
      last_rdata = mem_word(a);
    end else begin
      check("miss_stall", 32'(imem_stall), 1);
      check("miss_resp",  32'(imem_resp),  0);
      // Fetch side keeps presenting the request while stalled.
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        check("req_read",   32'(bmem_read), 1);
        check("req_addr",   bmem_addr,      {a[31:5], 5'b00000});
        check("req_noresp", 32'(imem_resp), 0);
        @(negedge clk);
      end
      check("req_read", 32'(bmem_read), 1);
      check("req_addr", bmem_addr,      {a[31:5], 5'b00000});
      input_valid = 1'b0;
      imem_read   = 1'b0;
      bmem_ready  = 1'b1;
      @(negedge clk);
      bmem_ready = 1'b0;
      bursts++;
      check("fill_bread", 32'(bmem_read),  0);
      check("fill_stall", 32'(imem_stall), 1);
      killed = 1'b0;
      for (int k = 0; k < 4; k++) begin
        n = $urandom_range(0, 2);
        repeat (n) @(negedge clk);
        bmem_rvalid = 1'b1;
        bmem_rdata  = beat_data(a, k);
        if (k == flush_beat) begin
          flush  = 1'b1;
          killed = 1'b1;
        end
        @(negedge clk);
        bmem_rvalid = 1'b0;
        flush       = 1'b0;
        bmem_rdata  = {$urandom, $urandom};
        if (k == rst_beat) begin
          rst = 1'b0;
          #1;
          check_all_zero("rst_mid");
          model_clear();
          last_raddr = '0;
          last_rdata = '0;
          @(negedge clk);
          rst = 1'b1;
          for (int j = k + 1; j < 4; j++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = beat_data(a, j);
            @(negedge clk);
            check("post_rst_resp",  32'(imem_resp),  0);
            check("post_rst_stall", 32'(imem_stall), 0);
          end
          bmem_rvalid = 1'b0;
          return;
        end
        if (k < 3) check("fill_noresp", 32'(imem_resp), 0);
      end
      check("done_stall", 32'(imem_stall), 0);
      ref_valid[idx_of(a)] = 1'b1;
      ref_line[idx_of(a)]  = a[31:5];
      if (killed) begin
        check("flush_noresp",     32'(imem_resp), 0);
        check("flush_raddr_hold", imem_raddr,     last_raddr);
        check("flush_rdata_hold", imem_rdata,     last_rdata);
      end else begin
        check("fill_resp",  32'(imem_resp), 1);
        check("fill_rdata", imem_rdata,     mem_word(a));
        check("fill_raddr", imem_raddr,     a);
        last_raddr = a;
        last_rdata = mem_word(a);
      end
    end
    // Nothing may be queued behind the answered request.
    @(negedge clk);
    check("no_queue", 32'(imem_resp), 0);
  endtask

  // Eight word fetches of one line on consecutive cycles.
  task automatic hit_run(input logic [31:0] base);
    logic [31:0] prev;
    prev = base;
    @(negedge clk);
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        check("b2b_resp",  32'(imem_resp),  1);
        check("b2b_raddr", imem_raddr,      prev);
        check("b2b_rdata", imem_rdata,      mem_word(prev));
        check("b2b_stall", 32'(imem_stall), 0);
      end
      if (i < 8) begin
        prev        = base + 32'(4 * i);
        input_valid = 1'b1;
        imem_read   = 1'b1;
        imem_addr   = prev;
        @(negedge clk);
      end else begin
        input_valid = 1'b0;
        imem_read   = 1'b0;
      end
    end
    last_raddr = prev;
    last_rdata = mem_word(prev);
  endtask

  // Directed scenarios followed by randomized fetches.
  initial begin
    int          b0;
    int          fb;
    logic [31:0] a;
    rst         = 1'b0;
    input_valid = 1'b0;
    imem_read   = 1'b0;
    imem_addr   = '0;
    flush       = 1'b0;
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'b0;
    bmem_rdata  = '0;
    last_raddr  = '0;
    last_rdata  = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Cold miss then a full line of back-to-back hits.
    fetch(32'h1000_0004, -1, -1);
    check("cold_bursts", 32'(bursts), 1);
    hit_run(32'h1000_0000);

    // Requests without imem_read, or coinciding with flush, are not taken.
    @(negedge clk);
    input_valid = 1'b1;
    imem_read   = 1'b0;
    imem_addr   = 32'h1000_0008;
    @(negedge clk);
    check("noread_resp",  32'(imem_resp),  0);
    check("noread_stall", 32'(imem_stall), 0);
    imem_read = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    check("flushreq_resp",  32'(imem_resp),  0);
    check("flushreq_stall", 32'(imem_stall), 0);
    input_valid = 1'b0;
    imem_read   = 1'b0;
    flush       = 1'b0;

    // Conflict eviction on index 0.
    b0 = bursts;
    fetch(32'h2000_0000, -1, -1);
    fetch(32'h2000_0100, -1, -1);
    fetch(32'h2000_0000, -1, -1);
    check("conflict_bursts", 32'(bursts - b0), 3);

    // Flush mid-fill: answer dropped, line still installed.
    fetch(32'h4000_0010, 2, -1);
    b0 = bursts;
    fetch(32'h4000_0010, -1, -1);
    check("flush_rehit_bursts", 32'(bursts - b0), 0);

    // Reset mid-fill: line not installed.
    fetch(32'h5000_0008, -1, 1);
    b0 = bursts;
    fetch(32'h5000_0008, -1, -1);
    check("rst_remiss_bursts", 32'(bursts - b0), 1);

    // Randomized fetches over a small region so hits and conflicts mix.
    for (int i = 0; i < 60; i++) begin
      a  = 32'h3000_0000 + 32'($urandom_range(0, 1023));
      fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      fetch(a, fb, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter LINES, default 8, meaning number of direct-mapped 32-byte lines (power of two, 2..64).
REQ-002 SHALL have port clk, in, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, in, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port input_valid, in, 1: fetch request qualifier.
REQ-005 SHALL have port imem_read, in, 1: fetch read request.
REQ-006 SHALL have port imem_addr, in, 32: fetch byte address.
REQ-007 SHALL have port flush, in, 1: kill any response not yet delivered.
REQ-008 SHALL have port imem_rdata, out, 32: returned instruction word.
REQ-009 SHALL have port imem_resp, out, 1: imem_rdata/imem_raddr valid this cycle.
REQ-010 SHALL have port imem_raddr, out, 32: address of the request being answered.
REQ-011 SHALL have port imem_stall, out, 1: responder busy; no new request accepted.
REQ-012 SHALL have ports bmem_addr (out, 32), bmem_read (out, 1), bmem_ready (in, 1), bmem_rvalid (in, 1) and bmem_rdata (in, 64) as the backing-memory burst read port.

Function
REQ-013 SHALL accept a request in cycle N iff input_valid && imem_read && !imem_stall && !flush.
REQ-014 SHALL map address bits as follows: offset addr[4:2] (word in line), index addr[4+log2(LINES):5], tag the remaining upper bits; addr[1:0] ignored for lookup.
REQ-015 SHALL implement FSM states IDLE, MISS_REQ and MISS_FILL; imem_stall = (state != IDLE), driven from registered state only.
REQ-016 SHALL, on hit (valid[index] && tag match) accepted in N: at N+1 drive imem_resp=1, imem_rdata=selected word, imem_raddr=imem_addr captured at N; throughput is one hit per cycle.
REQ-017 SHALL, on miss accepted in N, latch the address and enter MISS_REQ at N+1 with imem_resp=0 at N+1.
REQ-018 SHALL, in MISS_REQ, hold bmem_read=1 and bmem_addr={addr[31:5],5'b0} until bmem_ready is sampled 1, then enter MISS_FILL with the beat counter at 0.
REQ-019 SHALL, in MISS_FILL, place each bmem_rvalid beat k (0..3) into line bits [64k+63:64k]; the 2-bit counter wraps.
REQ-020 SHALL, on the 4th beat at cycle M: write the line, set valid and tag, return to IDLE at M+1, and drive imem_resp=1 at M+1 with the requested word taken from the fill data.
REQ-021 SHALL ignore bmem_rvalid outside MISS_FILL and bmem_ready outside MISS_REQ; bmem_read=0 outside MISS_REQ.
REQ-022 SHALL, on flush in any cycle, suppress the pending or future response of every already-accepted request (imem_resp=0, imem_raddr unchanged); a miss in progress completes its fill and installs the line.
REQ-023 SHALL hold imem_rdata and imem_raddr at their last values whenever imem_resp=0.
REQ-024 SHALL ignore requests while stalled; the fetch side holds its address, and no request is queued.

Reset
REQ-025 SHALL, while rst=0: clear all valid bits, state=IDLE, imem_resp=0, imem_stall=0, imem_rdata=0, imem_raddr=0, bmem_read=0, bmem_addr=0 and beat counter=0.
REQ-026 SHALL, when rst asserts mid-fill, abandon the burst immediately; the line is not installed and beats arriving after release are ignored.

Verification
REQ-027 SHALL cover cold miss: request 0x1000_0004 after reset -> imem_stall=1 next cycle, bmem_addr=0x1000_0000, 4 beats returned, imem_resp=1 with beat0[63:32] and imem_raddr=0x1000_0004 one cycle after beat 4.
REQ-028 SHALL cover back-to-back hits: addresses 0x1000_0000, 0x1000_0004, ... 0x1000_001C on consecutive cycles -> eight consecutive imem_resp pulses, each one cycle late, with matching raddr and no stall.
REQ-029 SHALL cover conflict eviction (LINES=8): 0x1000_0000 then 0x1000_0100 (same index) then 0x1000_0000 -> three misses and three bursts.
REQ-030 SHALL cover flush mid-fill: flush at beat 2 -> no imem_resp for that request, line installed, and a re-request of the same address hits with 1-cycle latency.
REQ-031 SHALL cover reset mid-fill: rst=0 after beat 1 -> all outputs 0, and the same address misses again after release.
